sum_io_ram_arbiter: RTL and testbench
=====================================

# sum_io_ram_arbiter

Two-client arbiter and sequencer for the sum_io dual-port accumulation RAM (read port 0, byte-enabled write port 1, 1-cycle read latency). Each port is shared round-robin between two requesters. Addresses outside the RAM window are rejected, read/write address collisions are resolved, and read data is returned to the issuing client with a valid tag. Sits between the HLS compute kernels and the sum_io RAM instance.

## Interface
- DWIDTH, 800, data word width
- AWIDTH, 13, address width
- MEM_SIZE, 1000, RAM depth in words
- ADDR_TOP, 5000, one past the highest legal address; window base = ADDR_TOP-MEM_SIZE (4000)
- NUM_COL, DWIDTH/8, byte lanes per word

Ports (client i occupies slice i of each packed vector, i in {0,1}):
- clk  in  1  single clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- rd_req  in  2  read request, held until rd_gnt
- rd_addr  in  2*AWIDTH  read addresses
- rd_gnt  out  2  read accepted this cycle
- rd_vld  out  2  one-hot read return strobe
- rd_err  out  1  returned read was out of window (qualified by rd_vld)
- rd_data  out  DWIDTH  returned data (qualified by rd_vld)
- wr_req  in  2  write request, held until wr_gnt
- wr_addr  in  2*AWIDTH  write addresses
- wr_be  in  2*NUM_COL  byte enables
- wr_data  in  2*DWIDTH  write data
- wr_gnt  out  2  write accepted this cycle
- wr_err  out  2  pulse, cycle after an out-of-window write grant
- ram_addr0 / ram_ce0  out  AWIDTH / 1  RAM read port
- ram_q0  in  DWIDTH  RAM read data
- ram_addr1 / ram_ce1  out  AWIDTH / 1  RAM write port
- ram_we1 / ram_d1  out  NUM_COL / DWIDTH  RAM write enables and data

## Operation
- Request/grant: a client asserts req with stable payload; the transfer occurs in the cycle gnt=1. Grants are combinational from req and registered state. At most one grant per port per cycle.
- Round-robin per port: a 1-bit last-grant register. With both requesting, the client not granted last wins. Any grant sets the pointer to the granted client. After reset the pointer favours client 0.
- Window check: legal iff 4000 <= addr <= 4999. The address is passed to the RAM untranslated, because the RAM applies the offset itself.
- Write grant, legal address: ram_ce1=1 and ram_we1/ram_d1/ram_addr1 come from the winner. wr_be all-zero is still granted and consumes the cycle.
- Write grant, illegal address: ram_ce1=0 and wr_err[i] pulses the next cycle.
- Read grant, legal address: ram_ce0=1. Next cycle rd_vld[i]=1, rd_err=0, rd_data=ram_q0.
- Read grant, illegal address: ram_ce0=0. Next cycle rd_vld[i]=1, rd_err=1, rd_data=0.
- Collision: if the winning read address equals a legal write address granted in the same cycle, the read is not granted. The read pointer is unchanged and the read retries next cycle. Reads and writes to different addresses proceed in parallel.
- Read returns are tagged by a registered client index plus an error bit. No reordering.

## Timing
- Grant latency 0 cycles from req when the port is free; write-to-RAM latency 0; read return latency exactly 1 cycle after rd_gnt.
- Back-to-back: one read and one write per cycle sustained.
- Reset values: rd_vld=0, rd_err=0, rd_data=0, wr_err=0, both pointers=client 1 last. Grants and RAM enables are 0 while reset_n=0.
- Reset asserted with a read in flight: the return is discarded; no rd_vld follows deassertion.
- rd_data is don't-care when rd_vld=0, but it must not glitch to X in simulation after reset.
- Write-then-read of the same address in consecutive cycles returns the new data.

## Structure
- Package sum_io_pkg holds:
  - window base/top constants;
  - a NUM_COL helper;
  - a 1-bit client-id type and the return-tag struct {vld, id, err}.
- Sub-module rr_arb2 is a two-way round-robin arbiter with req[1:0], an advance input, gnt[1:0] and its own pointer. It is instantiated once per port.
- The collision check and window compare are in the top level.

## Test plan
- Both clients read legal addresses 4000/4001 continuously -> grants alternate 0,1,0,1; rd_vld one-hot one cycle later with matching data.
- Client 0 writes 4010 (all bytes 0xAA) while client 1 reads 4010 in the same cycle -> rd_gnt[1]=0 that cycle. The read is granted next cycle and returns 0xAA in every byte.
- Write to address 3999 and read from 5000 -> ram_ce1/ram_ce0 stay 0; wr_err pulses the next cycle; rd_vld=1 with rd_err=1 and rd_data=0.
- Write with wr_be=lane 0 only onto a word preset to 0x55 -> readback has lane 0 updated and all other lanes 0x55.
- Assert reset_n low the cycle after a read grant -> no rd_vld after release; the first contended request goes to client 0.
- Sustained read on client 0 and write on client 1 to different addresses -> both granted every cycle for 100 cycles with no stalls.

Source files
------------

// File: rtl/sum_io_ram_arbiter_pkg.sv
// ============================================================================
// sum_io_pkg : shared constants and types for the sum_io RAM arbiter  (rev 1.0)
// ============================================================================
`default_nettype none

package sum_io_pkg;

    localparam int unsigned WIN_BASE = 4000;
    localparam int unsigned WIN_TOP  = 5000;

    function automatic int num_col(input int dwidth);
        return dwidth / 8;
    endfunction

    typedef logic client_id_t;

    typedef struct packed {
        logic       vld;
        client_id_t id;
        logic       err;
    } rtn_tag_t;

endpackage

`default_nettype wire

// File: rtl/sum_io_ram_arbiter_rr_arb2.sv
// ============================================================================
// rr_arb2 : two-way round-robin arbiter with a 1-bit last-grant pointer  (rev 1.0)
// ============================================================================
`default_nettype none

module rr_arb2 (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    output logic [1:0] gnt_o
);

    logic last_q;
    logic last_d;

    always_comb begin
        gnt_o = 2'b00;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
    end

    // The pointer only moves when the caller confirms the candidate grant.
    always_comb begin
        last_d = last_q;
        if (advance_i && (|gnt_o)) begin
            last_d = gnt_o[1];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/sum_io_ram_arbiter.sv
// ============================================================================
// sum_io_ram_arbiter : two-client read/write arbiter for the sum_io RAM  (rev 1.0)
// ============================================================================
`default_nettype none

module sum_io_ram_arbiter
    import sum_io_pkg::*;
#(
    parameter int DWIDTH   = 800,
    parameter int AWIDTH   = 13,
    parameter int MEM_SIZE = WIN_TOP - WIN_BASE,
    parameter int ADDR_TOP = WIN_TOP,
    parameter int NUM_COL  = num_col(DWIDTH)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            rd_req,
    input  logic [2*AWIDTH-1:0]   rd_addr,
    output logic [1:0]            rd_gnt,
    output logic [1:0]            rd_vld,
    output logic                  rd_err,
    output logic [DWIDTH-1:0]     rd_data,
    input  logic [1:0]            wr_req,
    input  logic [2*AWIDTH-1:0]   wr_addr,
    input  logic [2*NUM_COL-1:0]  wr_be,
    input  logic [2*DWIDTH-1:0]   wr_data,
    output logic [1:0]            wr_gnt,
    output logic [1:0]            wr_err,
    output logic [AWIDTH-1:0]     ram_addr0,
    output logic                  ram_ce0,
    input  logic [DWIDTH-1:0]     ram_q0,
    output logic [AWIDTH-1:0]     ram_addr1,
    output logic                  ram_ce1,
    output logic [NUM_COL-1:0]    ram_we1,
    output logic [DWIDTH-1:0]     ram_d1
);

    localparam logic [AWIDTH-1:0] c_win_lo = AWIDTH'(ADDR_TOP - MEM_SIZE);
    localparam logic [AWIDTH-1:0] c_win_hi = AWIDTH'(ADDR_TOP - 1);

    function automatic logic in_window(input logic [AWIDTH-1:0] a);
        return (a >= c_win_lo) && (a <= c_win_hi);
    endfunction

    logic [1:0]         w_rd_cand;
    logic [1:0]         w_wr_cand;
    logic [AWIDTH-1:0]  w_rd_addr;
    logic [AWIDTH-1:0]  w_wr_addr;
    logic [NUM_COL-1:0] w_wr_be;
    logic [DWIDTH-1:0]  w_wr_data;
    logic               w_rd_legal;
    logic               w_wr_legal;
    logic               w_collide;
    logic               w_rd_adv;

    rtn_tag_t           tag_q;
    rtn_tag_t           tag_d;
    logic [1:0]         wr_err_q;
    logic [1:0]         wr_err_d;

    rr_arb2 u_rd_arb (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_i     (rd_req),
        .advance_i (w_rd_adv),
        .gnt_o     (w_rd_cand)
    );

    rr_arb2 u_wr_arb (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_i     (wr_req),
        .advance_i (reset_n),
        .gnt_o     (w_wr_cand)
    );

    assign w_rd_addr  = w_rd_cand[1] ? rd_addr[2*AWIDTH-1:AWIDTH]   : rd_addr[AWIDTH-1:0];
    assign w_wr_addr  = w_wr_cand[1] ? wr_addr[2*AWIDTH-1:AWIDTH]   : wr_addr[AWIDTH-1:0];
    assign w_wr_be    = w_wr_cand[1] ? wr_be[2*NUM_COL-1:NUM_COL]   : wr_be[NUM_COL-1:0];
    assign w_wr_data  = w_wr_cand[1] ? wr_data[2*DWIDTH-1:DWIDTH]   : wr_data[DWIDTH-1:0];
    assign w_rd_legal = in_window(w_rd_addr);
    assign w_wr_legal = in_window(w_wr_addr);

    // A read hitting the word being written this cycle waits; pointer holds.
    assign w_collide  = (|w_wr_cand) & w_wr_legal & (|w_rd_cand) & (w_rd_addr == w_wr_addr);
    assign w_rd_adv   = reset_n & ~w_collide;

    assign rd_gnt     = w_rd_cand & {2{w_rd_adv}};
    assign wr_gnt     = w_wr_cand & {2{reset_n}};

    assign ram_addr0  = w_rd_addr;
    assign ram_ce0    = (|rd_gnt) & w_rd_legal;
    assign ram_addr1  = w_wr_addr;
    assign ram_ce1    = (|wr_gnt) & w_wr_legal;
    assign ram_we1    = w_wr_be & {NUM_COL{ram_ce1}};
    assign ram_d1     = w_wr_data;

    always_comb begin
        tag_d.vld = |rd_gnt;
        tag_d.id  = rd_gnt[1];
        tag_d.err = ~w_rd_legal;
        wr_err_d  = wr_gnt & {2{~w_wr_legal}};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tag_q    <= '0;
            wr_err_q <= '0;
        end else begin
            tag_q    <= tag_d;
            wr_err_q <= wr_err_d;
        end
    end

    assign rd_vld  = {tag_q.vld & tag_q.id, tag_q.vld & ~tag_q.id};
    assign rd_err  = tag_q.vld & tag_q.err;
    assign rd_data = (tag_q.vld && !tag_q.err) ? ram_q0 : '0;
    assign wr_err  = wr_err_q;

endmodule

`default_nettype wire

// File: tb/tb_sum_io_ram_arbiter.sv
// ============================================================================
// tb_sum_io_ram_arbiter : scoreboard bench for sum_io_ram_arbiter  (rev 1.0)
// ============================================================================
`default_nettype none

module tb_sum_io_ram_arbiter;

    localparam int DW  = 800;
    localparam int AW  = 13;
    localparam int NC  = DW / 8;
    localparam int BASE = 4000;
    localparam int DEPTH = 1000;

    typedef struct {
        logic [1:0]    oh;
        logic          err;
        logic [DW-1:0] data;
    } exp_t;

    logic               clk;
    logic               reset_n;
    logic [1:0]         rd_req;
    logic [2*AW-1:0]    rd_addr;
    logic [1:0]         rd_gnt;
    logic [1:0]         rd_vld;
    logic               rd_err;
    logic [DW-1:0]      rd_data;
    logic [1:0]         wr_req;
    logic [2*AW-1:0]    wr_addr;
    logic [2*NC-1:0]    wr_be;
    logic [2*DW-1:0]    wr_data;
    logic [1:0]         wr_gnt;
    logic [1:0]         wr_err;
    logic [AW-1:0]      ram_addr0;
    logic               ram_ce0;
    logic [DW-1:0]      ram_q0;
    logic [AW-1:0]      ram_addr1;
    logic               ram_ce1;
    logic [NC-1:0]      ram_we1;
    logic [DW-1:0]      ram_d1;

    logic [DW-1:0]      mem    [DEPTH];
    logic [DW-1:0]      shadow [DEPTH];
    exp_t               sb_q[$];
    int                 n_checks;
    int                 n_errors;

    sum_io_ram_arbiter dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .rd_gnt    (rd_gnt),
        .rd_vld    (rd_vld),
        .rd_err    (rd_err),
        .rd_data   (rd_data),
        .wr_req    (wr_req),
        .wr_addr   (wr_addr),
        .wr_be     (wr_be),
        .wr_data   (wr_data),
        .wr_gnt    (wr_gnt),
        .wr_err    (wr_err),
        .ram_addr0 (ram_addr0),
        .ram_ce0   (ram_ce0),
        .ram_q0    (ram_q0),
        .ram_addr1 (ram_addr1),
        .ram_ce1   (ram_ce1),
        .ram_we1   (ram_we1),
        .ram_d1    (ram_d1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [DW-1:0] init_word(input int i);
        logic [DW-1:0] w;
        for (int k = 0; k < DW / 32; k++) begin
            w[k*32 +: 32] = 32'(i) * 32'h9E37_79B1 + 32'(k);
        end
        return w;
    endfunction

    function automatic logic legal(input logic [AW-1:0] a);
        return (int'(a) >= BASE) && (int'(a) < BASE + DEPTH);
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // RAM model: 1-cycle read latency, byte-enabled write port
    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = init_word(i);
        forever begin
            @(posedge clk);
            if (ram_ce1 && legal(ram_addr1)) begin
                for (int k = 0; k < NC; k++) begin
                    if (ram_we1[k]) mem[int'(ram_addr1) - BASE][k*8 +: 8] <= ram_d1[k*8 +: 8];
                end
            end
            if (ram_ce0) begin
                ram_q0 <= legal(ram_addr0) ? mem[int'(ram_addr0) - BASE] : '0;
            end
        end
    end

    // Scoreboard: pop the return owed this cycle, then record new grants
    initial begin
        exp_t          e;
        logic          c;
        logic [AW-1:0] a;
        logic [NC-1:0] be;
        logic [DW-1:0] d;
        for (int i = 0; i < DEPTH; i++) shadow[i] = init_word(i);
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                sb_q.delete();
            end else begin
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    chk("rd_vld", rd_vld, e.oh);
                    chk("rd_err", rd_err, e.err);
                    chk("rd_data", rd_data, e.data);
                end else begin
                    chk("idle_vld", rd_vld, 2'b00);
                end
                if (|wr_gnt) begin
                    c  = wr_gnt[1];
                    a  = c ? wr_addr[2*AW-1:AW] : wr_addr[AW-1:0];
                    be = c ? wr_be[2*NC-1:NC]   : wr_be[NC-1:0];
                    d  = c ? wr_data[2*DW-1:DW] : wr_data[DW-1:0];
                    if (legal(a)) begin
                        for (int k = 0; k < NC; k++) begin
                            if (be[k]) shadow[int'(a) - BASE][k*8 +: 8] = d[k*8 +: 8];
                        end
                    end
                end
                if (|rd_gnt) begin
                    c     = rd_gnt[1];
                    a     = c ? rd_addr[2*AW-1:AW] : rd_addr[AW-1:0];
                    e.oh  = c ? 2'b10 : 2'b01;
                    e.err = ~legal(a);
                    e.data = legal(a) ? shadow[int'(a) - BASE] : '0;
                    sb_q.push_back(e);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset_n  = 1'b0;
        rd_req   = 2'b11;
        rd_addr  = {13'(4001), 13'(4000)};
        wr_req   = 2'b11;
        wr_addr  = {13'(4003), 13'(4002)};
        wr_be    = '1;
        wr_data  = '0;

        // Reset state, with requests present
        @(negedge clk);
        chk("rst_rd_gnt", rd_gnt, 2'b00);
        chk("rst_wr_gnt", wr_gnt, 2'b00);
        chk("rst_ce", {ram_ce0, ram_ce1}, 2'b00);
        chk("rst_rd_vld", rd_vld, 2'b00);
        chk("rst_rd_err", rd_err, 1'b0);
        chk("rst_rd_data", rd_data, '0);
        chk("rst_wr_err", wr_err, 2'b00);
        step();
        rd_req  = 2'b00;
        wr_req  = 2'b00;
        reset_n = 1'b1;
        step();

        // Contended reads alternate starting at client 0
        rd_req = 2'b11;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rr_rd_gnt", rd_gnt, (i % 2 == 0) ? 2'b01 : 2'b10);
            step();
        end
        rd_req = 2'b00;
        step();

        // Read collides with same-cycle write to 4010
        wr_req  = 2'b01;
        wr_addr = {13'(0), 13'(4010)};
        wr_be   = {{NC{1'b0}}, {NC{1'b1}}};
        wr_data = {{DW{1'b0}}, {NC{8'hAA}}};
        rd_req  = 2'b10;
        rd_addr = {13'(4010), 13'(0)};
        @(negedge clk);
        chk("col_wr_gnt", wr_gnt, 2'b01);
        chk("col_rd_gnt", rd_gnt, 2'b00);
        chk("col_ce1", ram_ce1, 1'b1);
        step();
        wr_req = 2'b00;
        @(negedge clk);
        chk("col_retry_gnt", rd_gnt, 2'b10);
        step();
        rd_req = 2'b00;
        @(negedge clk);
        chk("col_data", rd_data, {NC{8'hAA}});
        step();

        // Out-of-window write (3999) and read (5000)
        wr_req  = 2'b01;
        wr_addr = {13'(0), 13'(3999)};
        rd_req  = 2'b10;
        rd_addr = {13'(5000), 13'(0)};
        @(negedge clk);
        chk("oow_wr_gnt", wr_gnt, 2'b01);
        chk("oow_rd_gnt", rd_gnt, 2'b10);
        chk("oow_ce", {ram_ce0, ram_ce1}, 2'b00);
        step();
        wr_req = 2'b00;
        rd_req = 2'b00;
        @(negedge clk);
        chk("oow_wr_err", wr_err, 2'b01);
        chk("oow_rd_vld", rd_vld, 2'b10);
        chk("oow_rd_err", rd_err, 1'b1);
        chk("oow_rd_data", rd_data, '0);
        step();
        @(negedge clk);
        chk("oow_wr_err_clr", wr_err, 2'b00);
        step();

        // Partial byte-enable write onto a 0x55 word, then read back
        wr_req  = 2'b10;
        wr_addr = {13'(4020), 13'(0)};
        wr_be   = {{NC{1'b1}}, {NC{1'b0}}};
        wr_data = {{NC{8'h55}}, {DW{1'b0}}};
        @(negedge clk);
        chk("be_preset_gnt", wr_gnt, 2'b10);
        step();
        wr_req  = 2'b01;
        wr_addr = {13'(0), 13'(4020)};
        wr_be   = {{NC{1'b0}}, {(NC-1){1'b0}}, 1'b1};
        wr_data = {{DW{1'b0}}, {NC{8'h11}}};
        @(negedge clk);
        chk("be_lane_gnt", wr_gnt, 2'b01);
        step();
        wr_req  = 2'b00;
        rd_req  = 2'b01;
        rd_addr = {13'(0), 13'(4020)};
        @(negedge clk);
        chk("be_rd_gnt", rd_gnt, 2'b01);
        step();
        rd_req = 2'b00;
        @(negedge clk);
        chk("be_data", rd_data, {{(NC-1){8'h55}}, 8'h11});
        step();

        // Reset with a read in flight; pointer was left at client 0
        rd_req  = 2'b01;
        rd_addr = {13'(0), 13'(4000)};
        @(negedge clk);
        chk("inflight_gnt", rd_gnt, 2'b01);
        #1;
        reset_n = 1'b0;
        #1;
        chk("rst_mid_gnt", rd_gnt, 2'b00);
        @(negedge clk);
        chk("rst_mid_vld", rd_vld, 2'b00);
        step();
        rd_req  = 2'b00;
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_vld", rd_vld, 2'b00);
            step();
        end
        rd_req  = 2'b11;
        rd_addr = {13'(4003), 13'(4002)};
        @(negedge clk);
        chk("post_rst_rr", rd_gnt, 2'b01);
        step();
        rd_req = 2'b00;
        step();
        step();

        // Sustained parallel read (client 0) and write (client 1)
        for (int i = 0; i < 100; i++) begin
            rd_req  = 2'b01;
            rd_addr = {13'(0), 13'(4100 + (i % 50))};
            wr_req  = 2'b10;
            wr_addr = {13'(4500 + i), 13'(0)};
            wr_be   = '1;
            for (int k = 0; k < DW / 32; k++) begin
                wr_data[DW + k*32 +: 32] = $urandom;
            end
            @(negedge clk);
            chk("sustain_gnt", {rd_gnt, wr_gnt}, 4'b0110);
            step();
        end
        rd_req = 2'b00;
        wr_req = 2'b00;
        step();
        step();
        @(negedge clk);
        chk("sb_empty", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
